// File: rtl/clock_pkg.sv
// Shared definitions for the settable time-of-day clock: mode encoding,
// field widths and field maxima. Used by clock_set_ctrl and its bench.
package clock_pkg;

   // Mode encoding is visible on the mode port; 2'd3 is never produced.
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2
   } mode_t;

   localparam int HR_W    = 5;
   localparam int MIN_W   = 6;
   localparam int SEC_W   = 6;

   localparam int HR_MAX  = 23;
   localparam int MIN_MAX = 59;
   localparam int SEC_MAX = 59;

   // Mode sequence advanced by each mode_pulse; the illegal encoding
   // (and anything unexpected) recovers to RUN.
   function automatic mode_t next_mode(input mode_t cur);
      mode_t nxt;
      case (cur)
         RUN:     nxt = SET_HR;
         SET_HR:  nxt = SET_MIN;
         default: nxt = RUN;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo counter for one time field (0..MAX). inc advances the value,
// clr forces it to zero and has priority. wrap is a combinational carry:
// high in the cycle where an inc moves the value from MAX back to 0.
module mod_counter #(
   parameter int W   = 6,
   parameter int MAX = 59
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] value,
   output logic         wrap
);

   logic at_max;

   // Values above MAX cannot occur from reset, but are treated as the
   // wrap point so the field can never stick outside its range.
   assign at_max = (value >= W'(MAX));
   assign wrap   = inc && !clr && at_max;

   // Field register: async reset, clear beats increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc) begin
         value <= at_max ? '0 : value + 1'b1;
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day clock (hh:mm:ss) with a two-button setting interface.
// mode_pulse cycles RUN -> SET_HR -> SET_MIN -> RUN; inc_pulse bumps the
// field being set. The time only advances in RUN, one second per
// TICK_DIV clk_in cycles. Leaving SET_MIN restarts the second from zero.
// Optional display blinking during setting is built when the macro
// CLOCK_SET_BLINK_EN is defined; otherwise the blank outputs are tied low.
// Pulse inputs are single-cycle strobes, sampled on every rising edge with
// no handshake; a pulse is acted on at the edge where it is high.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int TICK_DIV = 100000000
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             mode_pulse,
   input  logic             inc_pulse,
   output logic [HR_W-1:0]  hours,
   output logic [MIN_W-1:0] minutes,
   output logic [SEC_W-1:0] seconds,
   output logic [1:0]       mode,
   output logic             blank_hr,
   output logic             blank_min
);

   localparam int              PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

   mode_t            state_q;
   mode_t            state_d;
   logic [PS_W-1:0]  prescaler;
   logic [PS_W-1:0]  prescaler_d;

   logic tick;
   logic run_tick;
   logic set_inc;
   logic leaving_set_min;
   logic sec_inc;
   logic min_inc;
   logic hr_inc;
   logic sec_wrap;
   logic min_wrap;
   logic day_wrap_unused;

   assign tick            = (prescaler == PS_MAX);
   assign run_tick        = (state_q == RUN) && tick;
   // A coincident mode_pulse wins over inc_pulse.
   assign set_inc         = inc_pulse && !mode_pulse;
   assign leaving_set_min = (state_q == SET_MIN) && mode_pulse;

   // Prescaler next value: free-running in every mode, restarted when the
   // user commits the time by leaving SET_MIN.
   always_comb begin
      prescaler_d = prescaler + 1'b1;
      if (leaving_set_min || tick) begin
         prescaler_d = '0;
      end
   end

   // Prescaler register.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler_d;
      end
   end

   // Mode next-state: only mode_pulse moves the FSM; an illegal
   // encoding falls back to RUN on the next cycle.
   always_comb begin
      state_d = state_q;
      if (state_q != RUN && state_q != SET_HR && state_q != SET_MIN) begin
         state_d = RUN;
      end else if (mode_pulse) begin
         state_d = next_mode(state_q);
      end
   end

   // Mode register; its value is the mode output.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign mode = state_q;

   // Field increments: ticks ripple through the carries only in RUN;
   // setting a field never carries into the next one.
   assign sec_inc = run_tick;
   assign min_inc = (run_tick && sec_wrap) || ((state_q == SET_MIN) && set_inc);
   assign hr_inc  = (run_tick && min_wrap) || ((state_q == SET_HR) && set_inc);

   mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
      .clk   (clk_in),
      .rst   (rst),
      .inc   (sec_inc),
      .clr   (leaving_set_min),
      .value (seconds),
      .wrap  (sec_wrap)
   );

   mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
      .clk   (clk_in),
      .rst   (rst),
      .inc   (min_inc),
      .clr   (1'b0),
      .value (minutes),
      .wrap  (min_wrap)
   );

   mod_counter #(.W(HR_W), .MAX(HR_MAX)) u_hr (
      .clk   (clk_in),
      .rst   (rst),
      .inc   (hr_inc),
      .clr   (1'b0),
      .value (hours),
      .wrap  (day_wrap_unused)
   );

`ifdef CLOCK_SET_BLINK_EN
   localparam logic [PS_W-1:0] PS_HALF = PS_W'(TICK_DIV / 2);

   // Blank the field being set during the second half of each second.
   // Built from next-state values so the registered output lines up with
   // the prescaler and mode registers in the same cycle.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         blank_hr  <= 1'b0;
         blank_min <= 1'b0;
      end else begin
         blank_hr  <= (state_d == SET_HR)  && (prescaler_d >= PS_HALF);
         blank_min <= (state_d == SET_MIN) && (prescaler_d >= PS_HALF);
      end
   end
`else
   assign blank_hr  = 1'b0;
   assign blank_min = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl with TICK_DIV=4: directed run, rollover,
// setting, coincident-pulse and async-reset sequences, plus a vector table
// for the setting walk. Blink expectations follow CLOCK_SET_BLINK_EN.
module tb_clock_set_ctrl;

   localparam int TICK_DIV = 4;

   typedef struct {
      logic mp;
      logic ip;
      int   hr;
      int   mn;
      int   sc;
      int   md;
   } vec_t;

   logic       clk_in = 1'b0;
   logic       rst = 1'b1;
   logic       mode_pulse = 1'b0;
   logic       inc_pulse = 1'b0;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic [1:0] mode;
   logic       blank_hr;
   logic       blank_min;

   int   checks = 0;
   int   passes = 0;
   int   ps_model = 0;
   vec_t tbl[$];

   clock_set_ctrl #(.TICK_DIV(TICK_DIV)) dut (
      .clk_in     (clk_in),
      .rst        (rst),
      .mode_pulse (mode_pulse),
      .inc_pulse  (inc_pulse),
      .hours      (hours),
      .minutes    (minutes),
      .seconds    (seconds),
      .mode       (mode),
      .blank_hr   (blank_hr),
      .blank_min  (blank_min)
   );

   always #5 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic pulse(input logic mp, input logic ip);
      mode_pulse = mp;
      inc_pulse  = ip;
      step();
      mode_pulse = 1'b0;
      inc_pulse  = 1'b0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         passes++;
      end
   endtask

   task automatic check_time(input string tag, input int h, input int m, input int s, input int md);
      check({tag, ".hours"},   32'(hours),   32'(h));
      check({tag, ".minutes"}, 32'(minutes), 32'(m));
      check({tag, ".seconds"}, 32'(seconds), 32'(s));
      check({tag, ".mode"},    32'(mode),    32'(md));
   endtask

   function automatic int exp_blank(input int ps);
`ifdef CLOCK_SET_BLINK_EN
      return (ps >= TICK_DIV / 2) ? 1 : 0;
`else
      return (ps < 0) ? 1 : 0;
`endif
   endfunction

   function automatic void add(input logic mp, input logic ip, input int h,
                               input int m, input int s, input int md);
      vec_t v;
      v.mp = mp; v.ip = ip; v.hr = h; v.mn = m; v.sc = s; v.md = md;
      tbl.push_back(v);
   endfunction

   initial begin
      // Setting walk starting from 00:01:00, RUN, prescaler 0.
      add(1'b1, 1'b0, 0, 1, 0, 1);                        // RUN -> SET_HR
      for (int k = 1; k <= 25; k++) add(1'b0, 1'b1, k % 24, 1, 0, 1);
      add(1'b1, 1'b1, 1, 1, 0, 2);                        // coincident: mode wins
      for (int k = 2; k <= 59; k++) add(1'b0, 1'b1, 1, k, 0, 2);
      add(1'b0, 1'b1, 1, 0, 0, 2);                        // 59 -> 0, no carry
      add(1'b1, 1'b0, 1, 0, 0, 0);                        // SET_MIN -> RUN, clears
      add(1'b0, 1'b1, 1, 0, 0, 0);                        // inc ignored in RUN
      add(1'b0, 1'b0, 1, 0, 0, 0);
      add(1'b0, 1'b0, 1, 0, 0, 0);
      add(1'b0, 1'b0, 1, 0, 1, 0);                        // 4th edge after clear

      // Reset state.
      repeat (3) step();
      check_time("reset", 0, 0, 0, 0);
      check("reset.blank_hr",  32'(blank_hr),  0);
      check("reset.blank_min", 32'(blank_min), 0);

      // Free run: first tick on the 4th edge, one minute after 240 edges.
      rst = 1'b0;
      repeat (3) step();
      check("pre_tick.seconds", 32'(seconds), 0);
      step();
      check("first_tick.seconds", 32'(seconds), 1);
      repeat (236) step();
      check_time("run_240", 0, 1, 0, 0);

      // Table-driven setting walk.
      foreach (tbl[i]) begin
         mode_pulse = tbl[i].mp;
         inc_pulse  = tbl[i].ip;
         step();
         mode_pulse = 1'b0;
         inc_pulse  = 1'b0;
         check_time($sformatf("vec%0d", i), tbl[i].hr, tbl[i].mn, tbl[i].sc, tbl[i].md);
      end

      // Preload 23:59 through the set modes, then roll over the day.
      pulse(1'b1, 1'b0);
      repeat (22) pulse(1'b0, 1'b1);
      check_time("preload_hr", 23, 0, 1, 1);
      pulse(1'b1, 1'b0);
      repeat (59) pulse(1'b0, 1'b1);
      check_time("preload_min", 23, 59, 1, 2);
      pulse(1'b1, 1'b0);
      check_time("commit", 23, 59, 0, 0);
      repeat (239) step();
      check_time("before_rollover", 23, 59, 59, 0);
      step();
      check_time("rollover", 0, 0, 0, 0);

      // Async reset in the middle of SET_MIN, asserted between edges.
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      check_time("mid_set_min", 0, 2, 0, 2);
      #2;
      rst = 1'b1;
      #1;
      check_time("async_rst", 0, 0, 0, 0);
      check("async_rst.blank_hr",  32'(blank_hr),  0);
      check("async_rst.blank_min", 32'(blank_min), 0);
      step();
      rst = 1'b0;
      ps_model = 0;
      check_time("after_rst", 0, 0, 0, 0);

      // Blink phase in SET_HR, then in SET_MIN.
      pulse(1'b1, 1'b0);
      ps_model = 1;
      check("blink_hr_entry.mode", 32'(mode), 1);
      check("blink_hr_entry.blank_hr", 32'(blank_hr), 32'(exp_blank(ps_model)));
      for (int c = 0; c < 8; c++) begin
         step();
         ps_model = (ps_model + 1) % TICK_DIV;
         check($sformatf("blink_hr%0d.blank_hr", c),  32'(blank_hr),  32'(exp_blank(ps_model)));
         check($sformatf("blink_hr%0d.blank_min", c), 32'(blank_min), 0);
      end
      pulse(1'b1, 1'b0);
      ps_model = (ps_model + 1) % TICK_DIV;
      check("blink_min_entry.mode", 32'(mode), 2);
      for (int c = 0; c < 4; c++) begin
         step();
         ps_model = (ps_model + 1) % TICK_DIV;
         check($sformatf("blink_min%0d.blank_min", c), 32'(blank_min), 32'(exp_blank(ps_model)));
         check($sformatf("blink_min%0d.blank_hr", c),  32'(blank_hr),  0);
      end
      check_time("blink_end", 0, 0, 0, 2);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, giving clk_in cycles per one-second tick (minimum 4, even).
REQ-002 SHALL have port clk_in, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port mode_pulse, input, 1 bit: one-cycle debounced pulse from the pushbutton stage; advances the mode.
REQ-005 SHALL have port inc_pulse, input, 1 bit: one-cycle debounced pulse from the pushbutton stage; increments the field being set.
REQ-006 SHALL have port hours, output, 5 bits: binary hours, 0..23.
REQ-007 SHALL have port minutes, output, 6 bits: binary minutes, 0..59.
REQ-008 SHALL have port seconds, output, 6 bits: binary seconds, 0..59.
REQ-009 SHALL have port mode, output, 2 bits: current state encoding (RUN=0, SET_HR=1, SET_MIN=2).
REQ-010 SHALL have port blank_hr, output, 1 bit: display blanking request for the hours digits.
REQ-011 SHALL have port blank_min, output, 1 bit: display blanking request for the minutes digits.

Function
REQ-012 SHALL keep a prescaler counting 0..TICK_DIV-1 and wrapping; tick is asserted for the one cycle in which prescaler == TICK_DIV-1.
REQ-013 SHALL implement states RUN, SET_HR, SET_MIN; on mode_pulse: RUN->SET_HR, SET_HR->SET_MIN, SET_MIN->RUN; no other transitions.
REQ-014 SHALL, in RUN on tick: seconds+1; 59 wraps to 0 with carry to minutes; minutes 59 wraps to 0 with carry to hours; hours 23 wraps to 0 (23:59:59 -> 00:00:00 in one tick).
REQ-015 SHALL, in SET_HR and SET_MIN, keep the prescaler running but discard ticks; the time is frozen except for inc_pulse.
REQ-016 SHALL, in SET_HR on inc_pulse, increment hours mod 24 only, without affecting minutes or seconds.
REQ-017 SHALL, in SET_MIN on inc_pulse, increment minutes mod 60 only, with no carry into hours.
REQ-018 SHALL ignore inc_pulse in RUN.
REQ-019 SHALL, on the SET_MIN->RUN transition, clear seconds and the prescaler to 0 in that same cycle.
REQ-020 SHALL, when mode_pulse and inc_pulse coincide, take the mode transition and ignore inc_pulse.
REQ-021 SHALL register all outputs; any change is visible on the first clk_in edge after the causing pulse or tick (latency 1).
REQ-022 SHALL NOT hold an undefined encoding 3; if mode is ever 3, the next cycle SHALL go to RUN.

Reset
REQ-023 SHALL, while rst=1 and independently of clk_in, force hours=0, minutes=0, seconds=0, mode=RUN, prescaler=0, blank_hr=0, blank_min=0.
REQ-024 SHALL, when reset is asserted mid-set, abandon the setting and leave no partial state.

Configuration
REQ-025 SHALL, with macro CLOCK_SET_BLINK_EN defined, assert blank_hr in SET_HR and blank_min in SET_MIN whenever prescaler >= TICK_DIV/2, and hold both at 0 otherwise.
REQ-026 SHALL, without CLOCK_SET_BLINK_EN, tie blank_hr and blank_min to constant 0 and compile in no blink logic.

Structure
REQ-027 SHALL take the state enum, HR_MAX=23, MIN_MAX=59, SEC_MAX=59 and the field widths from shared package clock_pkg.
REQ-028 SHALL instantiate sub-module mod_counter (parameterised modulus; inc, clr inputs; value and wrap outputs) for the seconds, minutes and hours fields.

Verification (bench uses TICK_DIV=4)
REQ-029 SHALL cover: reset, then 4*60 cycles in RUN -> 00:01:00, mode=0.
REQ-030 SHALL cover: the time preloaded via set mode to 23:59, then 60 ticks -> 00:00:00 on the 60th tick edge.
REQ-031 SHALL cover: mode_pulse, then 25 inc_pulses -> hours=1, mode=1, minutes and seconds unchanged.
REQ-032 SHALL cover: in SET_MIN at 59, an inc_pulse -> minutes=0 with hours unchanged; then mode_pulse -> mode=0, seconds=0, prescaler=0.
REQ-033 SHALL cover: mode_pulse and inc_pulse in the same cycle from SET_HR -> mode=2 and hours unchanged.
REQ-034 SHALL cover: rst pulse mid-SET_MIN between clock edges -> all outputs 0 immediately; with CLOCK_SET_BLINK_EN in SET_HR, blank_hr=1 exactly when prescaler is 2..3.
